// File: rtl/xmul_mpmul_seq_if.sv
// Request/response bundle of the shared xmul unit.
// The master issues requests and receives responses.
interface xmul_mpmul_seq_if;
  logic        req_valid;
  logic        req_dw;
  logic [5:0]  req_fn;
  logic [4:0]  req_tag;
  logic [63:0] req_in1;
  logic [63:0] req_in2;
  logic [63:0] req_in3;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;

  modport master (
    output req_valid, req_dw, req_fn, req_tag,
    output req_in1, req_in2, req_in3,
    input  resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_dw, req_fn, req_tag,
    input  req_in1, req_in2, req_in3,
    output resp_data, resp_tag
  );
endinterface

// File: rtl/xmul_mpmul_seq.sv
// 256x256->512 multiply sequencer on the shared xmul unit.
// Core requests have strict priority; sequencer fills idle slots.
module xmul_mpmul_seq #(
  parameter logic [4:0] SEQ_TAG  = 5'd31,
  parameter logic [5:0] FN_MADDL = 6'd50,
  parameter logic [5:0] FN_MADDH = 6'd51
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [255:0]  opa,
  input  logic [255:0]  opb,
  output logic          busy,
  output logic          done,
  output logic [511:0]  prod,
  xmul_mpmul_seq_if.slave  core,
  xmul_mpmul_seq_if.master mul
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t        state;
  logic [255:0]  a_q, b_q;
  logic [63:0]   p [8];
  logic [63:0]   carry, lo_r;
  logic [4:0]    iss_cnt, cap_cnt;
  logic          v1, v2;

  logic          grant, cap, cap_last;
  logic [1:0]    ii, ij, ci, cj;
  logic [2:0]    isum, csum, crow;
  logic [64:0]   s;
  logic [63:0]   hi_c;

  assign grant = (state == ISSUE) && !core.req_valid;
  assign ii    = iss_cnt[4:3];
  assign ij    = iss_cnt[2:1];
  assign isum  = {1'b0, ii} + {1'b0, ij};

  assign cap      = v2 && (mul.resp_tag == SEQ_TAG);
  assign cap_last = cap && (cap_cnt == 5'd31);
  assign ci       = cap_cnt[4:3];
  assign cj       = cap_cnt[2:1];
  assign csum     = {1'b0, ci} + {1'b0, cj};
  assign crow     = {1'b0, ci} + 3'd4;
  assign s        = {1'b0, lo_r} + {1'b0, carry};
  assign hi_c     = mul.resp_data + {63'd0, s[64]};

  assign prod = {p[7], p[6], p[5], p[4],
                 p[3], p[2], p[1], p[0]};

  assign core.resp_data = mul.resp_data;
  assign core.resp_tag  = mul.resp_tag;

  always_comb begin
    mul.req_valid = core.req_valid;
    mul.req_dw    = core.req_dw;
    mul.req_fn    = core.req_fn;
    mul.req_tag   = core.req_tag;
    mul.req_in1   = core.req_in1;
    mul.req_in2   = core.req_in2;
    mul.req_in3   = core.req_in3;
    if (grant) begin
      mul.req_valid = 1'b1;
      mul.req_dw    = 1'b1;
      mul.req_fn    = iss_cnt[0] ? FN_MADDH
                                 : FN_MADDL;
      mul.req_tag   = SEQ_TAG;
      mul.req_in1   = a_q[{ij, 6'd0} +: 64];
      mul.req_in2   = b_q[{ii, 6'd0} +: 64];
      mul.req_in3   = p[isum];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry   <= '0;
      lo_r    <= '0;
      iss_cnt <= '0;
      cap_cnt <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      for (int k = 0; k < 8; k++) p[k] <= '0;
    end else begin
      done <= 1'b0;
      v1   <= grant;
      v2   <= v1;
      if (grant) iss_cnt <= iss_cnt + 5'd1;
      if (cap) begin
        cap_cnt <= cap_cnt + 5'd1;
        if (!cap_cnt[0]) begin
          lo_r <= mul.resp_data;
        end else begin
          p[csum] <= s[63:0];
          // row end: final carry becomes the new top limb
          if (cj == 2'd3) begin
            p[crow] <= hi_c;
            carry   <= '0;
          end else begin
            carry <= hi_c;
          end
        end
      end
      unique case (state)
        IDLE: if (start) begin
          state   <= ISSUE;
          busy    <= 1'b1;
          a_q     <= opa;
          b_q     <= opb;
          carry   <= '0;
          iss_cnt <= '0;
          cap_cnt <= '0;
          for (int k = 0; k < 8; k++) p[k] <= '0;
        end
        ISSUE: if (grant && iss_cnt == 5'd31)
          state <= DRAIN;
        DRAIN: if (cap_last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xmul_mpmul_seq.sv
// Scoreboard bench for xmul_mpmul_seq with a 2-cycle xmul model.
// Expected products and core responses are queued at issue time.
module tb_xmul_mpmul_seq;
  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] opa, opb;
  logic         busy, done;
  logic [511:0] prod;

  xmul_mpmul_seq_if core_if ();
  xmul_mpmul_seq_if mul_if ();

  xmul_mpmul_seq dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .opa   (opa),
    .opb   (opb),
    .busy  (busy),
    .done  (done),
    .prod  (prod),
    .core  (core_if),
    .mul   (mul_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] prod;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  tag;
    logic [63:0] data;
  } cexp_t;

  exp_t  exp_q [$];
  cexp_t core_q [$];
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic logic [63:0] xm(
    input logic [5:0] fn,
    input logic [63:0] a, b, c);
    logic [127:0] t;
    t = {64'd0, a} * {64'd0, b} + {64'd0, c};
    return (fn == 6'd51) ? t[127:64] : t[63:0];
  endfunction

  // xmul model: fixed 2-cycle latency, shares reset
  logic        mv1, mv2;
  logic [4:0]  mt1, mt2;
  logic [63:0] md1, md2;
  always @(posedge clock) begin
    if (reset) begin
      mv1 <= 1'b0; mv2 <= 1'b0;
      mt1 <= '0;   mt2 <= '0;
      md1 <= '0;   md2 <= '0;
    end else begin
      mv1 <= mul_if.req_valid;
      mt1 <= mul_if.req_tag;
      md1 <= xm(mul_if.req_fn, mul_if.req_in1,
                mul_if.req_in2, mul_if.req_in3);
      mv2 <= mv1;
      mt2 <= mt1;
      md2 <= md1;
    end
  end
  assign mul_if.resp_data = md2;
  assign mul_if.resp_tag  = mv2 ? mt2 : 5'd0;

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // monitor: pops expectations when the DUT presents results
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("prod", prod, e.prod);
          if (e.cyc >= 0)
            chk("done_cycle", edge_cnt, e.cyc);
        end
      end
      if (mv2 && mt2 != 5'd31) begin
        if (core_q.size() == 0) begin
          chk("unexpected_core_resp", 1'b1, 1'b0);
        end else begin
          cexp_t c;
          c = core_q.pop_front();
          chk("core_tag", core_if.resp_tag, c.tag);
          chk("core_data", core_if.resp_data, c.data);
        end
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_core(input logic [4:0] tag);
    cexp_t c;
    core_if.req_valid = 1'b1;
    core_if.req_dw    = 1'b1;
    core_if.req_fn    = 6'd50 + 6'($urandom_range(1));
    core_if.req_tag   = tag;
    core_if.req_in1   = {$urandom, $urandom};
    core_if.req_in2   = {$urandom, $urandom};
    core_if.req_in3   = {$urandom, $urandom};
    c.tag  = tag;
    c.data = xm(core_if.req_fn, core_if.req_in1,
                core_if.req_in2, core_if.req_in3);
    core_q.push_back(c);
  endtask

  task automatic run_op(
    input logic [255:0] a, b, b2,
    input logic [511:0] ep,
    input int rs, cs, cl,
    input bit rnd, cb,
    input int ed);
    exp_t e;
    int   c0;
    c0    = edge_cnt;
    e.prod = ep;
    e.cyc  = (ed < 0) ? -1 : c0 + ed;
    exp_q.push_back(e);
    opa   = a;
    opb   = b;
    start = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n > 0 && exp_q.size() == 0) break;
      if (cb && n >= 1 && n <= 35)
        chk("busy", busy, n <= 34);
      if (n > 0 && n == rs) begin
        start = 1'b1;
        opb   = b2;
      end else if (n > 0) begin
        start = 1'b0;
      end
      core_if.req_valid = 1'b0;
      if (n >= cs && n < cs + cl)
        drive_core(5'(n - cs + 1));
      else if (rnd && $urandom_range(3) == 0)
        drive_core(5'($urandom_range(30)));
      step;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 1'b1, 1'b0);
      exp_q.delete();
    end
    start = 1'b0;
    core_if.req_valid = 1'b0;
    repeat (3) step;
  endtask

  logic [255:0] ra, rb;
  logic [511:0] ones;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    opa = '0;
    opb = '0;
    core_if.req_valid = 1'b0;
    core_if.req_dw    = 1'b0;
    core_if.req_fn    = '0;
    core_if.req_tag   = '0;
    core_if.req_in1   = '0;
    core_if.req_in2   = '0;
    core_if.req_in3   = '0;
    repeat (3) step;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", prod, 512'd0);
    reset = 1'b0;
    step;

    // small operands, exact timing and busy window
    run_op(256'd2, 256'd3, 256'd0, 512'd6,
           -1, -1, 0, 1'b0, 1'b1, 35);

    // all-ones squared
    ones = {{255{1'b1}}, 256'd0, 1'b1};
    run_op({256{1'b1}}, {256{1'b1}}, 256'd0, ones,
           -1, -1, 0, 1'b0, 1'b0, 35);

    // single limbs landing on the row-end slot
    run_op(256'd1 << 64, 256'd1 << 192, 256'd0,
           512'd1 << 256,
           -1, -1, 0, 1'b0, 1'b0, 35);

    // core holds the unit for 5 cycles
    run_op(256'hFFFF_FFFF_FFFF_FFFF,
           256'hFFFF_FFFF_FFFF_FFFF, 256'd0,
           512'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
           -1, 10, 5, 1'b0, 1'b0, 40);

    // second start while busy is ignored
    run_op(256'd5, 256'd7, 256'd11, 512'd35,
           12, -1, 0, 1'b0, 1'b0, 35);

    // reset mid-operation
    opa   = 256'd9;
    opb   = 256'd9;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (19) step;
    reset = 1'b1;
    step;
    chk("abort_busy", busy, 1'b0);
    chk("abort_prod", prod, 512'd0);
    reset = 1'b0;
    step;
    run_op(256'h1_0000_0000_0000_0001,
           256'h1_0000_0000_0000_0001, 256'd0,
           512'h1_0000_0000_0000_0002_0000_0000_0000_0001,
           -1, -1, 0, 1'b0, 1'b0, 35);

    // random operands with random core traffic
    for (int t = 0; t < 30; t++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      run_op(ra, rb, 256'd0,
             {256'd0, ra} * {256'd0, rb},
             -1, -1, 0, 1'b1, 1'b0, -1);
    end

    repeat (4) step;
    chk("exp_q_empty", exp_q.size(), 0);
    chk("core_q_empty", core_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
